// File: rtl/sram_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_pkg
//  Purpose  : Shared widths, bus encodings and arbiter states for the SRAM bus.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_bus_pkg;

    localparam int          c_ADDR_W   = 19;
    localparam int          c_DATA_W   = 16;
    localparam int          c_BE_W     = 2;
    localparam logic        c_RW_READ  = 1'b1;
    localparam logic        c_RW_WRITE = 1'b0;
    localparam logic [15:0] c_ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Combinational two-request round-robin picker, one-hot result.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import sram_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_pick
);

    // On a tie the master that was not served last wins.
    always_comb begin
        o_pick = 2'b00;
        case (i_req)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = i_last_grant ? 2'b01 : 2'b10;
            default: o_pick = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_arbiter
//  Purpose  : Two-master round-robin arbiter with watchdog in front of the
//             SRAM controller bridge bus.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                DATA_W   = c_DATA_W,
    parameter int                BE_W     = c_BE_W,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(c_ERR_DATA)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_bus_enable,
    input  logic [BE_W-1:0]   m0_byte_enable,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_acknowledge,
    output logic [DATA_W-1:0] m0_read_data,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_bus_enable,
    input  logic [BE_W-1:0]   m1_byte_enable,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_acknowledge,
    output logic [DATA_W-1:0] m1_read_data,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_bus_enable,
    output logic [BE_W-1:0]   s_byte_enable,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_write_data,
    input  logic              s_acknowledge,
    input  logic [DATA_W-1:0] s_read_data,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_s_address;
    logic              r_s_bus_enable;
    logic [BE_W-1:0]   r_s_byte_enable;
    logic              r_s_rw;
    logic [DATA_W-1:0] r_s_write_data;
    logic [1:0]        r_grant;
    logic              r_timeout_err;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic              w_busy;
    logic              w_expired;
    logic              w_done;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;

    assign w_req = {m1_bus_enable, m0_bus_enable};

    rr_arbiter2 u_rr (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick)
    );

    // The watchdog fires once the count of BUSY cycles without an acknowledge
    // has reached TIMEOUT; a real acknowledge in that same cycle takes priority.
    assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_expired = (TIMEOUT != 0) && (r_cnt == c_TIMEOUT);
    assign w_done    = w_busy && (s_acknowledge || w_expired);
    assign w_err     = w_done && !s_acknowledge;
    assign w_rdata   = s_acknowledge ? s_read_data : ERR_DATA;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick[0]) begin
                    w_state_nxt = BUSY0;
                end else if (w_pick[1]) begin
                    w_state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (w_done) begin
                    w_state_nxt = TURN;
                end
            end
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_last_grant    <= 1'b1;
            r_cnt           <= '0;
            r_s_address     <= '0;
            r_s_bus_enable  <= 1'b0;
            r_s_byte_enable <= '0;
            r_s_rw          <= 1'b0;
            r_s_write_data  <= '0;
            r_grant         <= 2'b00;
            r_timeout_err   <= 1'b0;
        end else begin
            r_timeout_err <= w_err;
            case (r_state)
                IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_cnt           <= '0;
                        r_grant         <= w_pick;
                        r_s_bus_enable  <= 1'b1;
                        r_s_address     <= w_pick[0] ? m0_address     : m1_address;
                        r_s_byte_enable <= w_pick[0] ? m0_byte_enable : m1_byte_enable;
                        r_s_rw          <= w_pick[0] ? m0_rw          : m1_rw;
                        r_s_write_data  <= w_pick[0] ? m0_write_data  : m1_write_data;
                    end
                end
                BUSY0, BUSY1: begin
                    if (w_done) begin
                        r_last_grant    <= (r_state == BUSY1);
                        r_grant         <= 2'b00;
                        r_s_bus_enable  <= 1'b0;
                        r_s_address     <= '0;
                        r_s_byte_enable <= '0;
                        r_s_rw          <= 1'b0;
                        r_s_write_data  <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_acknowledge = (r_state == BUSY0) && w_done;
    assign m1_acknowledge = (r_state == BUSY1) && w_done;
    assign m0_read_data   = m0_acknowledge ? w_rdata : '0;
    assign m1_read_data   = m1_acknowledge ? w_rdata : '0;

    assign s_address     = r_s_address;
    assign s_bus_enable  = r_s_bus_enable;
    assign s_byte_enable = r_s_byte_enable;
    assign s_rw          = r_s_rw;
    assign s_write_data  = r_s_write_data;
    assign grant         = r_grant;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Two-master arbiter that sits directly upstream of the SRAM controller and shares its single bridge-style bus (address / bus_enable / byte_enable / rw / write_data / acknowledge / read_data).
- Master 0 is the Nios II bridge port; master 1 is a second bus master (DMA/fill engine).
- Round-robin arbitration, one transaction in flight, registered slave-side outputs.
- Watchdog timeout so a missing slave acknowledge cannot hang either master.

Parameters:
ADDR_W, 19, address width of masters and slave
DATA_W, 16, data width
BE_W, 2, byte-enable width (DATA_W/8)
TIMEOUT, 255, cycles to wait for s_acknowledge before forcing an error completion; 0 disables the watchdog
ERR_DATA, 16'hDEAD, read_data returned on a timed-out read

Ports:
clk_clk  in  1  system clock; all logic on rising edge
reset_reset_n  in  1  reset; one clock; reset is synchronous and active-low
m0_address, m1_address  in  ADDR_W  master word address
m0_bus_enable, m1_bus_enable  in  1  request; held high until that master's acknowledge
m0_byte_enable, m1_byte_enable  in  BE_W  byte lanes
m0_rw, m1_rw  in  1  1 = read, 0 = write
m0_write_data, m1_write_data  in  DATA_W  write data
m0_acknowledge, m1_acknowledge  out  1  one-cycle completion pulse
m0_read_data, m1_read_data  out  DATA_W  read data, valid with acknowledge
s_address  out  ADDR_W  to SRAM controller
s_bus_enable  out  1  to SRAM controller
s_byte_enable  out  BE_W  to SRAM controller
s_rw  out  1  to SRAM controller
s_write_data  out  DATA_W  to SRAM controller
s_acknowledge  in  1  from SRAM controller, one-cycle pulse
s_read_data  in  DATA_W  from SRAM controller
grant  out  2  one-hot current owner, 00 when idle
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (sync, active-low): state = IDLE; last_grant = 1, so m0 wins first; timeout counter = 0. All outputs are 0, including s_* and grant.
- FSM states: IDLE, BUSY0, BUSY1, TURN.
- IDLE:
  - Sample m*_bus_enable.
  - Only one master requesting: grant it.
  - Both requesting: grant the master opposite last_grant.
  - On grant (next edge): latch that master's address, byte_enable, rw and write_data into the s_* registers; s_bus_enable = 1; grant updated; enter BUSYn. Request-to-s_bus_enable latency is exactly 1 cycle.
- BUSYn:
  - s_* registers hold constant.
  - On s_acknowledge: mn_acknowledge = 1 combinationally in the same cycle, and mn_read_data = s_read_data.
  - Next edge: s_bus_enable = 0, grant = 00, last_grant = n, enter TURN.
- TURN: exactly one cycle with s_bus_enable low (slave turnaround), then IDLE.
  - A master re-requesting immediately sees its next grant no earlier than 2 cycles after its acknowledge.
  - The other master is preferred by round-robin.
- Read data:
  - The non-granted master's acknowledge is always 0.
  - Its read_data is 0 when not acknowledged.
  - Writes also return acknowledge; read_data is don't-care but is driven as s_read_data.
- Watchdog:
  - Counter clears on entry to BUSYn and increments each BUSY cycle.
  - If the count reaches TIMEOUT without s_acknowledge: mn_acknowledge pulses with mn_read_data = ERR_DATA, timeout_err pulses, and the FSM goes to TURN.
  - If s_acknowledge and the timeout coincide, the real acknowledge wins; no error.
- Master drops bus_enable while BUSY (protocol violation): the transaction continues to completion; the acknowledge is still pulsed and ignored by the master.
- s_acknowledge in IDLE or TURN: ignored; no master acknowledge is generated.
- Reset asserted mid-transaction: next edge returns to IDLE with s_bus_enable = 0. The in-flight transaction is abandoned with no acknowledge to the master.
- No combinational path from m*_bus_enable to s_*.
- The only combinational paths are s_acknowledge/s_read_data to m*_acknowledge/m*_read_data.

Decomposition:
- Shared package sram_bus_pkg holds:
  - ADDR_W, DATA_W, BE_W
  - RW_READ = 1, RW_WRITE = 0
  - arbiter state enum {IDLE, BUSY0, BUSY1, TURN}
  - ERR_DATA default
- One natural sub-module, rr_arbiter2: combinational two-request round-robin picker taking req[1:0] and last_grant, producing a one-hot pick. The top holds the FSM, the request-latch registers and the watchdog.

Test Plan:
- Only m0 requests a read at 19'h00010; slave acks 3 cycles after s_bus_enable with 16'h1234 -> s_bus_enable rises 1 cycle after the request, m0_acknowledge pulses with m0_read_data = 16'h1234, grant = 01, then one TURN cycle with s_bus_enable = 0.
- m0 and m1 request together out of reset -> m0 served first. m1 (write 16'hBEEF, byte_enable 2'b10) is then served, with s_write_data = 16'hBEEF and s_byte_enable = 2'b10. While both keep requesting, grants alternate 01, 10, 01.
- Slave never acks, TIMEOUT = 8 -> 8 BUSY cycles, then m0_acknowledge with m0_read_data = 16'hDEAD and timeout_err pulses once.
- s_acknowledge arrives on the exact cycle the timeout expires -> real data is returned and timeout_err stays 0.
- reset_reset_n low for one cycle while in BUSY1 -> next cycle state IDLE, all s_* = 0, no m1_acknowledge. A pending m0 request is granted on the first cycle after reset is released.
- Spurious s_acknowledge in IDLE -> both m*_acknowledge stay 0.
